// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter that sequences commands onto a single-port sync RAM.
// Writes take one bus cycle, reads two (address phase, then the RAM drives the data bus).
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StWrite, StRdA, StRdD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  grant0, grant1;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      if (m0_req && (!m1_req || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (m1_req) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          addr_d       = grant1 ? m1_addr : m0_addr;
          wdata_d      = grant1 ? m1_wdata : m0_wdata;
          owner_d      = grant1;
          last_grant_d = grant1;
          state_d      = (grant1 ? m1_we : m0_we) ? StWrite : StRdA;
        end
      end
      StWrite: state_d = StIdle;
      StRdA:   state_d = StRdD;
      StRdD: begin
        rdata_d   = ram_data;
        rvalid0_d = !owner_q;
        rvalid1_d = owner_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rdata_q      <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // Controls are gated by reset so a write coinciding with reset never reaches the RAM.
  assign ram_cs    = rst_n && (state_q != StIdle);
  assign ram_we    = rst_n && (state_q == StWrite);
  assign ram_oe    = rst_n && (state_q == StRdD);
  assign ram_addr  = addr_q;
  assign ram_data  = ram_we ? wdata_q : 'z;
  assign busy      = (state_q != StIdle);

  assign m0_gnt    = grant0;
  assign m1_gnt    = grant1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule
